// File: rtl/btn_event_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | btn_event_pkg : event codes shared by the button event controller    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package btn_event_pkg;

  localparam int EVT_CODE_W = 2;

  localparam logic [EVT_CODE_W-1:0] EVT_NONE    = 2'b00;
  localparam logic [EVT_CODE_W-1:0] EVT_PRESS   = 2'b01;
  localparam logic [EVT_CODE_W-1:0] EVT_RELEASE = 2'b10;
  localparam logic [EVT_CODE_W-1:0] EVT_LONG    = 2'b11;

endpackage
`default_nettype wire

// File: rtl/btn_event_ctrl_channel.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | btn_channel : one button's debouncer, event classifier, pending slot |
// | Optional LONG events via BTN_EVENT_LONG_PRESS_EN. Rev 1.0            |
// +----------------------------------------------------------------------+
module btn_channel
  import btn_event_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int LONG_TICKS = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick,
  input  logic                  button,
  input  logic                  grant,
  output logic                  pending,
  output logic [EVT_CODE_W-1:0] code,
  output logic                  db_state,
  output logic                  ovf
);

  logic [DEPTH-1:0]      history;
  logic                  all_ones;
  logic                  all_zeros;
  logic                  rise;
  logic                  fall;
  logic                  long_evt;
  logic                  new_evt;
  logic [EVT_CODE_W-1:0] new_code;

  assign all_ones  = &history;
  assign all_zeros = ~|history;
  assign rise      = !db_state && all_ones;
  assign fall      = db_state && all_zeros;

`ifdef BTN_EVENT_LONG_PRESS_EN
  localparam int HW = $clog2(LONG_TICKS + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_TICKS);

  logic [HW-1:0] hold_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt <= '0;
    end else if (rise) begin
      hold_cnt <= '0;
    end else if (db_state && tick && (hold_cnt != HOLD_MAX)) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end

  // Fires only on the step into saturation, so once per press.
  assign long_evt = db_state && tick && (hold_cnt == HOLD_MAX - 1'b1);
`else
  // LONG_TICKS has no effect in this build; the comparison is constant false.
  assign long_evt = (LONG_TICKS < 0);
`endif

  assign new_evt  = rise || fall || long_evt;
  assign new_code = rise ? EVT_PRESS : (fall ? EVT_RELEASE : EVT_LONG);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      history  <= '0;
      db_state <= 1'b0;
      pending  <= 1'b0;
      code     <= EVT_NONE;
      ovf      <= 1'b0;
    end else begin
      if (tick) begin
        history <= (history << 1) | DEPTH'(button);
      end
      if (all_ones) begin
        db_state <= 1'b1;
      end else if (all_zeros) begin
        db_state <= 1'b0;
      end
      // A grant in the same clock frees the slot for the new event.
      if (new_evt) begin
        if (pending && !grant) begin
          ovf <= 1'b1;
        end else begin
          pending <= 1'b1;
          code    <= new_code;
        end
      end else if (grant) begin
        pending <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/btn_event_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | btn_event_ctrl : N-button debounce + PRESS/RELEASE/LONG event port   |
// | LONG events need BTN_EVENT_LONG_PRESS_EN. Rev 1.0                    |
// +----------------------------------------------------------------------+
module btn_event_ctrl
  import btn_event_pkg::*;
#(
  parameter int N          = 4,
  parameter int DIV        = 4,
  parameter int DEPTH      = 8,
  parameter int LONG_TICKS = 64,
  localparam int IW        = (N > 1) ? $clog2(N) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N-1:0]          buttons,
  output logic                  evt_valid,
  input  logic                  evt_ready,
  output logic [IW-1:0]         evt_id,
  output logic [EVT_CODE_W-1:0] evt_code,
  output logic [N-1:0]          db_state,
  output logic [N-1:0]          ovf
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] DIV_LAST = PW'(DIV - 1);
  localparam logic [IW-1:0] ID_LAST  = IW'(N - 1);

  logic [PW-1:0]         div_cnt;
  logic                  tick;
  logic [IW-1:0]         rr_ptr;
  logic [N-1:0]          pending;
  logic [N-1:0]          grant;
  logic [EVT_CODE_W-1:0] codes [N];
  logic                  load;
  logic                  found;
  logic [IW-1:0]         winner;

  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
    end
  end

  generate
    for (genvar i = 0; i < N; i++) begin : g_ch
      btn_channel #(
        .DEPTH      (DEPTH),
        .LONG_TICKS (LONG_TICKS)
      ) u_ch (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .button   (buttons[i]),
        .grant    (grant[i]),
        .pending  (pending[i]),
        .code     (codes[i]),
        .db_state (db_state[i]),
        .ovf      (ovf[i])
      );
    end
  endgenerate

  assign load = !evt_valid || evt_ready;

  // First pending channel at or after the pointer, wrapping modulo N.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    grant  = '0;
    for (int k = 0; k < N; k++) begin
      logic [IW-1:0] idx;
      idx = IW'((int'(rr_ptr) + k) % N);
      if (!found && pending[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
    if (load && found) begin
      grant[winner] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      evt_valid <= 1'b0;
      evt_id    <= '0;
      evt_code  <= EVT_NONE;
      rr_ptr    <= '0;
    end else if (load) begin
      evt_valid <= found;
      if (found) begin
        evt_id   <= winner;
        evt_code <= codes[winner];
        rr_ptr   <= (winner == ID_LAST) ? '0 : winner + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_btn_event_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_btn_event_ctrl : directed bench for btn_event_ctrl (N=4, DIV=4,   |
// | DEPTH=4, LONG_TICKS=16). Rev 1.0                                     |
// +----------------------------------------------------------------------+
module tb_btn_event_ctrl;

  localparam int N = 4;

  logic       clk;
  logic       reset;
  logic [3:0] buttons;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_id;
  logic [1:0] evt_code;
  logic [3:0] db_state;
  logic [3:0] ovf;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [3:0] ev_q [$];
  int         ev_t [$];

  btn_event_ctrl #(
    .N          (N),
    .DIV        (4),
    .DEPTH      (4),
    .LONG_TICKS (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .buttons   (buttons),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_id    (evt_id),
    .evt_code  (evt_code),
    .db_state  (db_state),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Handshaken events as {id, code} with the cycle they were taken.
  always @(negedge clk) begin
    if (!reset && evt_valid && evt_ready) begin
      ev_q.push_back({evt_id, evt_code});
      ev_t.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clocks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves time at 1 unit after edge P0; P1 is the first edge out of reset.
  task automatic start(input logic rdy);
    reset     = 1'b1;
    buttons   = '0;
    evt_ready = rdy;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    ev_q.delete();
    ev_t.delete();
  endtask

  initial begin
    reset     = 1'b1;
    buttons   = '0;
    evt_ready = 1'b1;
    clocks(2);
    check("rst_valid", 32'(evt_valid), 32'd0);
    check("rst_id",    32'(evt_id),    32'd0);
    check("rst_code",  32'(evt_code),  32'd0);
    check("rst_db",    32'(db_state),  32'd0);
    check("rst_ovf",   32'(ovf),       32'd0);

    // Single press: samples at P4..P16, db at P17, event on P18 only.
    start(1'b1);
    buttons = 4'b0100;
    clocks(16);
    check("t1_db_early", 32'(db_state), 32'h0);
    clocks(1);
    check("t1_db_rise",  32'(db_state), 32'h4);
    check("t1_no_valid", 32'(evt_valid), 32'd0);
    clocks(1);
    check("t1_valid",    32'(evt_valid), 32'd1);
    check("t1_id",       32'(evt_id),    32'd2);
    check("t1_code",     32'(evt_code),  32'd1);
    clocks(1);
    check("t1_valid_1clk", 32'(evt_valid), 32'd0);
    clocks(21);
    check("t1_count", 32'(ev_q.size()), 32'd1);
    check("t1_event", 32'(ev_q[0]), 32'h9);
    buttons = 4'b0000;
    clocks(30);
    check("t1_rel_count", 32'(ev_q.size()), 32'd2);
    check("t1_rel_event", 32'(ev_q[1]), 32'hA);

    // Bounce: toggling every 3 clocks never gives 4 equal samples.
    start(1'b1);
    for (int c = 0; c < 60; c++) begin
      if (c % 3 == 0) buttons[0] = ~buttons[0];
      clocks(1);
    end
    check("t2_db", 32'(db_state), 32'h0);
    buttons = 4'b0000;
    clocks(20);
    check("t2_events", 32'(ev_q.size()), 32'd0);
    check("t2_ovf",    32'(ovf),         32'h0);

    // Long press: LONG queued at the 16th tick after the db rise.
    start(1'b1);
    buttons = 4'b0010;
    clocks(100);
    buttons = 4'b0000;
    clocks(40);
`ifdef BTN_EVENT_LONG_PRESS_EN
    check("t3_count", 32'(ev_q.size()), 32'd3);
    check("t3_press", 32'(ev_q[0]), 32'h5);
    check("t3_long",  32'(ev_q[1]), 32'h7);
    check("t3_long_time", 32'(ev_t[1] - ev_t[0]), 32'd63);
    check("t3_release", 32'(ev_q[2]), 32'h6);
`else
    check("t3_count", 32'(ev_q.size()), 32'd2);
    check("t3_press", 32'(ev_q[0]), 32'h5);
    check("t3_release", 32'(ev_q[1]), 32'h6);
`endif
    check("t3_db_low", 32'(db_state), 32'h0);

    // Arbitration: simultaneous presses then releases, ids 0..3 each round.
    start(1'b1);
    buttons = 4'b1111;
    clocks(18);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t4_valid%0d", i), 32'(evt_valid), 32'd1);
      check($sformatf("t4_id%0d", i),    32'(evt_id),    32'(i));
      check($sformatf("t4_code%0d", i),  32'(evt_code),  32'd1);
      clocks(1);
    end
    check("t4_idle", 32'(evt_valid), 32'd0);
    buttons = 4'b0000;
    clocks(30);
    check("t4_count", 32'(ev_q.size()), 32'd8);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t4_rel%0d", i), 32'(ev_q[4+i]), 32'(i * 4 + 2));
      if (i > 0) check($sformatf("t4_rel_gap%0d", i), 32'(ev_t[4+i] - ev_t[3+i]), 32'd1);
    end

    // Backpressure: PRESS held, RELEASE waits in slot, later events overflow.
    start(1'b0);
    buttons = 4'b1000;
    clocks(18);
    check("t5_valid", 32'(evt_valid), 32'd1);
    check("t5_id",    32'(evt_id),    32'd3);
    check("t5_code",  32'(evt_code),  32'd1);
    clocks(12);
    buttons = 4'b0000;
    clocks(16);
    check("t5_ovf_clear", 32'(ovf), 32'h0);
    clocks(4);
    buttons = 4'b1000;
    clocks(16);
    check("t5_ovf_set", 32'(ovf), 32'h8);
    clocks(4);
    buttons = 4'b0000;
    clocks(20);
    check("t5_hold_valid", 32'(evt_valid), 32'd1);
    check("t5_hold_id",    32'(evt_id),    32'd3);
    check("t5_hold_code",  32'(evt_code),  32'd1);
    check("t5_none_yet",   32'(ev_q.size()), 32'd0);
    evt_ready = 1'b1;
    clocks(5);
    check("t5_count",   32'(ev_q.size()), 32'd2);
    check("t5_first",   32'(ev_q[0]), 32'hD);
    check("t5_second",  32'(ev_q[1]), 32'hE);
    check("t5_drained", 32'(evt_valid), 32'd0);
    check("t5_ovf_sticky", 32'(ovf), 32'h8);

    // Asynchronous reset between edges while an event is presented.
    start(1'b0);
    buttons = 4'b0100;
    clocks(18);
    check("t6_valid_pre", 32'(evt_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_valid", 32'(evt_valid), 32'd0);
    check("t6_id",    32'(evt_id),    32'd0);
    check("t6_code",  32'(evt_code),  32'd0);
    check("t6_db",    32'(db_state),  32'h0);
    check("t6_ovf",   32'(ovf),       32'h0);
    buttons = 4'b0000;
    clocks(2);
    reset     = 1'b0;
    evt_ready = 1'b1;
    clocks(40);
    check("t6_no_replay", 32'(ev_q.size()), 32'd0);
    check("t6_idle",      32'(evt_valid),   32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
